// File: rtl/serdes_data_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : serdes_data_buffer_if
// Description : Write/read handshake bundle for serdes_data_buffer.
//               The slave modport is the buffer side; the master modport is
//               the producer/consumer side driving writes and pop requests.
// Signals     : in_valid  - qualifies in_data (master -> slave)
//               in_data   - write word, DATA_W bits (master -> slave)
//               in_ready  - write accepted this cycle (slave -> master)
//               out_valid - out_data holds the oldest word (slave -> master)
//               out_data  - read word, DATA_W bits (slave -> master)
//               out_ready - pop request for the head word (master -> slave)
// Macro       : SERDES_DATA_BUFFER_PARITY_EN does not change this bundle;
//               out_par is a plain port of the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface serdes_data_buffer_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/serdes_data_buffer.sv
`default_nettype none
// ============================================================================
// Module      : serdes_data_buffer
// Description : First-word-fall-through data buffer with sticky overflow
//               flag, synchronous flush and occupancy count. The head word is
//               held in a dedicated output register so out_data always comes
//               straight from a flop.
// Ports       : clk      - rising-edge clock
//               rst_n    - synchronous active-low reset
//               flush    - synchronous clear of count and pointers
//               clr_ovf  - clears the sticky overflow flag
//               bus      - serdes_data_buffer_if.slave write/read handshake
//               count    - current occupancy, $clog2(DEPTH)+1 bits
//               ovf      - sticky overflow (write attempted while full)
//               out_par  - even parity of out_data (parity build only)
// Macro       : SERDES_DATA_BUFFER_PARITY_EN adds per-entry parity storage
//               and the out_par output.
// Revision    : 1.0 - initial release
// ============================================================================
module serdes_data_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 flush,
  input  wire logic                 clr_ovf,
  serdes_data_buffer_if.slave       bus,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      ovf
`ifdef SERDES_DATA_BUFFER_PARITY_EN
  ,
  output logic                      out_par
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] c_ONE  = CW'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_out_data;
  logic              r_ovf;

  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_push;
  logic              w_pop;
  logic [AW-1:0]     w_rptr_inc;
  logic              w_head_from_mem;
  logic              w_head_from_in;

  always_comb begin
    w_in_ready  = (r_count != c_FULL);
    w_out_valid = (r_count != '0);
    // A full buffer refuses writes even if a pop happens in the same cycle.
    w_push      = bus.in_valid  & w_in_ready  & ~flush;
    w_pop       = bus.out_ready & w_out_valid & ~flush;
    w_rptr_inc  = r_rptr + AW'(1);
    // The head register is refilled from the next stored entry when a pop
    // leaves older words behind; otherwise from the incoming word when the
    // buffer is (or becomes) empty at the moment of the push.
    w_head_from_mem = w_pop & (r_count > c_ONE);
    w_head_from_in  = w_push & (~w_out_valid | (w_pop & (r_count == c_ONE)));
  end

  // Storage array: no reset, only the head register is cleared.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_out_data <= '0;
    end else if (flush) begin
      // Head register keeps its value so out_data holds while empty.
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= w_rptr_inc;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_ONE;
        2'b01:   r_count <= r_count - c_ONE;
        default: r_count <= r_count;
      endcase
      if (w_head_from_mem) begin
        r_out_data <= r_mem[w_rptr_inc];
      end else if (w_head_from_in) begin
        r_out_data <= bus.in_data;
      end
    end
  end

  // Overflow set has priority over clear; flush does not touch it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (bus.in_valid && !w_in_ready) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

`ifdef SERDES_DATA_BUFFER_PARITY_EN
  logic r_par_mem [DEPTH];
  logic r_out_par;
  logic w_in_par;

  always_comb begin
    w_in_par = ^bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_par_mem[r_wptr] <= w_in_par;
    end
  end

  // Mirrors the head-register update so parity stays aligned with out_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_par <= 1'b0;
    end else if (!flush) begin
      if (w_head_from_mem) begin
        r_out_par <= r_par_mem[w_rptr_inc];
      end else if (w_head_from_in) begin
        r_out_par <= w_in_par;
      end
    end
  end

  assign out_par = r_out_par;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_out_data;
  assign count         = r_count;
  assign ovf           = r_ovf;

endmodule
`default_nettype wire

// File: doc/serdes_data_buffer.md
SERDES_DATA_BUFFER -- requirements
Module: serdes_data_buffer

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data word width in bits (legal range 1..64).
REQ-002 Parameter DEPTH, default 4, SHALL set the number of storage entries (power of two, legal range 2..64).
REQ-003 clk  input  1  SHALL be the single rising-edge clock for all state.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 flush  input  1  SHALL be a synchronous buffer clear.
REQ-006 in_valid  input  1  SHALL qualify in_data.
REQ-007 in_data  input  DATA_W  SHALL carry the write word.
REQ-008 in_ready  output  1  SHALL indicate that a write is accepted this cycle.
REQ-009 out_valid  output  1  SHALL indicate that out_data holds the oldest stored word.
REQ-010 out_data  output  DATA_W  SHALL carry the read word.
REQ-011 out_ready  input  1  SHALL request a pop of the head word.
REQ-012 count  output  $clog2(DEPTH)+1  SHALL report the current occupancy.
REQ-013 ovf  output  1  SHALL be a sticky overflow flag.
REQ-014 clr_ovf  input  1  SHALL clear ovf.

Function
REQ-015 A push SHALL occur on a rising edge when in_valid=1 and in_ready=1; in_ready SHALL equal (count != DEPTH).
REQ-016 A pop SHALL occur on a rising edge when out_valid=1 and out_ready=1; out_valid SHALL equal (count != 0).
REQ-017 Operation SHALL be first-word-fall-through: a word pushed at edge N SHALL be on out_data with out_valid=1 from edge N (1-cycle latency), when the buffer was empty.
REQ-018 out_data SHALL be driven from registered storage only; with out_valid=0, out_data SHALL hold its last value.
REQ-019 A simultaneous push and pop SHALL leave count unchanged and preserve order; this is legal at every occupancy 1..DEPTH-1.
REQ-020 When full, no push SHALL occur even if a pop happens in the same cycle; when empty, no pop SHALL occur.
REQ-021 Read and write pointers SHALL wrap from DEPTH-1 to 0 without a bubble.
REQ-022 ovf SHALL set on any edge where in_valid=1 and in_ready=0; the rejected word SHALL be discarded and stored data left intact.
REQ-023 clr_ovf=1 SHALL clear ovf at the next edge; when set and clear coincide, set SHALL win.
REQ-024 flush=1 SHALL, at the next edge, zero count and both pointers and ignore push and pop in that cycle; ovf and storage contents SHALL be unaffected.
REQ-025 Storage SHALL be edge-triggered flops; no level-sensitive latches SHALL be inferred.

Reset
REQ-026 When rst_n=0 at a rising edge, count, pointers and ovf SHALL become 0 and out_data SHALL become 0; rst_n SHALL take priority over flush, push, pop and clr_ovf.
REQ-027 After reset: in_ready=1 and out_valid=0; storage array contents other than the head output need not be cleared.
REQ-028 A reset asserted mid-operation SHALL discard all stored words; the first word pushed after reset SHALL be the first word popped.

Configuration
REQ-029 With macro SERDES_DATA_BUFFER_PARITY_EN defined, the block SHALL store one even-parity bit per word (computed from in_data at push) and add output out_par (1 bit), aligned with out_data and reset to 0.
REQ-030 Without SERDES_DATA_BUFFER_PARITY_EN, out_par SHALL NOT exist and storage SHALL be DATA_W bits per entry.

Verification (DATA_W=8, DEPTH=4)
REQ-031 Reset, then push 0xA5 -> next cycle out_valid=1, out_data=0xA5, count=1; pop -> count=0, out_valid=0.
REQ-032 Push 0x01..0x04 with out_ready=0 -> count=4, in_ready=0; push 0x05 -> ovf=1, then pops yield 0x01,0x02,0x03,0x04.
REQ-033 Hold count=2 with continuous push and pop for 10 cycles -> count stays 2 and the output sequence matches the input order across pointer wrap.
REQ-034 count=3, assert flush together with in_valid=1 -> count=0, out_valid=0, ovf unchanged; clr_ovf together with an overflow event -> ovf stays 1.
REQ-035 count=3, drive rst_n=0 for one edge -> count=0, ovf=0, out_data=0x00; a following push of 0x3C is the first word popped.
REQ-036 PARITY_EN defined: push 0x07 then 0x03 -> out_par=1 with 0x07 and 0 with 0x03.
